// File: rtl/spi_bitrev_slave.sv
// SPI slave test target: oversamples SCK/SS/MOSI on the system clock, receives a
// DATA_W-bit word MSB first and answers with the bit-reversed (or echoed) word.
module spi_bitrev_slave #(
   parameter int DATA_W = 8,
   parameter bit CPOL   = 1'b0,
   parameter bit CPHA   = 1'b0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              sck,
   input  logic              ss,
   input  logic              mosi,
   input  logic              mode,
   output logic              miso,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              frame_err
);
   localparam int CW = $clog2(DATA_W) + 1;

   typedef enum logic [1:0] {IDLE, RX, TX} state_t;

   // [0],[1] synchroniser, [2] history for edge detection
   logic [2:0] sck_q, ss_q;
   logic [1:0] mosi_q;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] sr_q, sr_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              mode_q, mode_d;
   logic              carry_q, carry_d;
   logic              miso_q, miso_d;
   logic              rx_valid_q, rx_valid_d;
   logic              ferr_q, ferr_d;

   logic              sck_chg, lead_e, trail_e, samp_e, shft_e, ss_hi, ss_fall;
   logic [DATA_W-1:0] word, word_rev;

   assign sck_chg = sck_q[1] ^ sck_q[2];
   assign lead_e  = sck_chg & (sck_q[1] != CPOL);
   assign trail_e = sck_chg & (sck_q[1] == CPOL);
   assign samp_e  = CPHA ? trail_e : lead_e;
   assign shft_e  = CPHA ? lead_e : trail_e;
   assign ss_hi   = ss_q[1];
   assign ss_fall = ~ss_q[1] & ss_q[2];
   assign word    = {sr_q[DATA_W-2:0], mosi_q[1]};

   always_comb begin
      word_rev = '0;
      for (int i = 0; i < DATA_W; i++) word_rev[i] = word[DATA_W-1-i];
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sr_d       = sr_q;
      tx_d       = tx_q;
      mode_d     = mode_q;
      carry_d    = carry_q;
      miso_d     = miso_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      ferr_d     = 1'b0;
      if (ss_hi) begin
         state_d = IDLE;
         miso_d  = 1'b1;
         // carry_q: bit 0 came from the closing edge of a completed TX, so a
         // release right there is a clean end of transfer, not an abort.
         if (state_q == TX || (state_q == RX && cnt_q > CW'(carry_q)))
            ferr_d = 1'b1;
      end else begin
         case (state_q)
            IDLE: if (ss_fall) begin
               state_d = RX;
               mode_d  = mode;
               cnt_d   = '0;
               sr_d    = '0;
               carry_d = 1'b0;
               miso_d  = 1'b1;
            end
            RX: if (samp_e) begin
               sr_d    = word;
               cnt_d   = cnt_q + 1'b1;
               carry_d = 1'b0;
               if (cnt_q == CW'(DATA_W - 1)) begin
                  rx_data_d  = word;
                  rx_valid_d = 1'b1;
                  tx_d       = mode_q ? word : word_rev;
                  state_d    = TX;
                  cnt_d      = '0;
               end
            end
            TX: begin
               if (shft_e && cnt_q != CW'(DATA_W)) begin
                  miso_d = tx_q[DATA_W-1];
                  tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                  cnt_d  = cnt_q + 1'b1;
               end else if (samp_e && cnt_q == CW'(DATA_W)) begin
                  // master samples the last TX bit here; same edge is RX bit 0
                  state_d = RX;
                  mode_d  = mode;
                  sr_d    = {{(DATA_W-1){1'b0}}, mosi_q[1]};
                  cnt_d   = CW'(1);
                  carry_d = 1'b1;
                  miso_d  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sck_q      <= {3{CPOL}};
         ss_q       <= '0;   // a fresh ss fall is required after reset
         mosi_q     <= '0;
         state_q    <= IDLE;
         cnt_q      <= '0;
         sr_q       <= '0;
         tx_q       <= '0;
         mode_q     <= 1'b0;
         carry_q    <= 1'b0;
         miso_q     <= 1'b1;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         sck_q      <= {sck_q[1:0], sck};
         ss_q       <= {ss_q[1:0], ss};
         mosi_q     <= {mosi_q[0], mosi};
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sr_q       <= sr_d;
         tx_q       <= tx_d;
         mode_q     <= mode_d;
         carry_q    <= carry_d;
         miso_q     <= miso_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         ferr_q     <= ferr_d;
      end
   end

   assign miso      = miso_q;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = ferr_q;
endmodule

// File: doc/spi_bitrev_slave.md
Name: spi_bitrev_slave

Overview:
Parametrised SPI slave peripheral, the clocked successor of the 8-bit SPI bit-reversal device model. It oversamples SCK/SS/MOSI on the system clock, receives a DATA_W-bit word MSB first, then returns either the bit-reversed or the unchanged word on MISO during the next DATA_W SCK cycles. It supports all four SPI modes via parameters, back-to-back frames, and error flagging. It sits behind the SoC SPI master as a test target in the peripheral tree.

Parameters:
DATA_W, 8, word length in bits; legal range 2..32
CPOL, 0, SCK idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
sck  input  1  SPI clock from master, asynchronous to clock
ss  input  1  slave select, active low, asynchronous
mosi  input  1  master-out data, asynchronous
mode  input  1  0 = return bit-reversed word, 1 = echo word unchanged; sampled at frame start
miso  output  1  slave-out data; idles high
rx_data  output  DATA_W  last complete received word
rx_valid  output  1  one-cycle pulse when rx_data updates
frame_err  output  1  one-cycle pulse on ss deassert mid-frame

Behaviour:
- Single clock and reset, as decided: one clock, `clock`; reset `reset` is synchronous and active-high.
- Reset values: miso=1, rx_data=0, rx_valid=0, frame_err=0, state=IDLE, bit counter=0, shift register=0. Reset mid-frame aborts the frame silently, with no frame_err.
- Input synchronisation: sck, ss and mosi each pass through a 2-flop synchroniser. Edges are detected on the synced sck with a third history flop.
- Edge definitions:
  - Leading edge = synced sck leaving CPOL; trailing edge = returning to CPOL.
  - Sample edge = leading if CPHA=0, else trailing. Shift edge = the other one.
- Timing: a pin edge takes effect 3 clock cycles later. SCK high and low times must each be at least 4 clock cycles, and mosi must be stable 3 cycles around the sample edge. Faster SCK is unsupported.
- States:
  - IDLE: miso=1. Synced ss falling moves to RX. On that move, latch mode, clear the counter and clear the shift register.
  - RX: each sample edge shifts mosi into the LSB of the shift register and increments the counter. On the DATA_W-th sample edge:
    - rx_data is set to the new word and rx_valid pulses in the following cycle.
    - The TX word is formed: mode=0 gives the bit-reverse of the word (bit k = word[DATA_W-1-k]); mode=1 gives the word unchanged.
    - Go to TX with the counter cleared. miso stays 1 during RX.
  - TX: each shift edge drives miso with the TX word MSB first and increments the counter.
    - The first TX shift edge is the one immediately following the last RX sample edge, so bit 0 is valid before the master's next sample edge in every mode.
    - After DATA_W bits have been driven, wait for the next sample edge. If ss is still low there, return to RX for a back-to-back frame, and that sample edge is captured as RX bit 0. Mode is re-latched on this return.
- ss high (synced) in any state: go to IDLE and set miso=1 in the same cycle as the detection.
  - frame_err pulses if the state was RX with counter>0, or TX before the final TX bit had been sampled.
  - No pulse if ss rises in RX with counter=0, or after a completed TX.
- Simultaneous events:
  - ss rise and an sck edge in the same cycle: ss wins and the edge is ignored.
  - rx_valid and frame_err never pulse in the same cycle.
- Counter width is clog2(DATA_W)+1. It never wraps within a frame.

Test Plan:
- DATA_W=8, CPOL=0, CPHA=0, mode=0: send 0xA1, then clock 8 dummy bits → rx_data=0xA1 with one rx_valid pulse; miso returns 0x85 MSB first; miso=1 before and after.
- Same configuration, mode=1, send 0x3C → miso returns 0x3C; then ss high → no frame_err.
- DATA_W=16, CPOL=1, CPHA=1, mode=0: send 0x1234 → response 0x2C48; repeat in all four CPOL/CPHA combinations with identical results.
- Back-to-back frames with ss held low: 0xA1 → 0x85, then 0x01 → 0x80; the second RX overlaps the last TX sample edge; rx_valid pulses twice.
- Abort: raise ss after 3 RX bits → frame_err single pulse, rx_data unchanged, miso=1. Repeat with the abort after 4 TX bits → frame_err pulse.
- Reset asserted for 1 cycle mid-TX → miso=1 and IDLE the next cycle with no frame_err; a following frame of 0xF0 returns 0x0F.
